// File: rtl/cacheline_burst_adapter_if.sv
// Cache-line / memory-burst signal bundle for cacheline_burst_adapter.
// The slave modport is the adapter's view; master is the cache+memory side.
interface cacheline_burst_adapter_if #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
);
    logic [s_line-1:0]  line_i;
    logic [s_line-1:0]  line_o;
    logic [31:0]        address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    logic [s_burst-1:0] burst_i;
    logic [s_burst-1:0] burst_o;
    logic [31:0]        address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Converts one whole-line cache read/write into a num_beats x s_burst memory burst,
// then pulses resp_o for one cycle. One transaction in flight, single line buffer.
module cacheline_burst_adapter #(
    parameter int s_offset = 5,
    parameter int s_line   = 256,
    parameter int s_burst  = 64
) (
    input logic                      clk,
    input logic                      rst,
    cacheline_burst_adapter_if.slave bus
);
    localparam int num_beats = s_line / s_burst;
    localparam int cw        = (num_beats > 1) ? $clog2(num_beats) : 1;
    localparam logic [cw-1:0] last_beat = cw'(num_beats - 1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t             state;
    logic [cw-1:0]      count;
    logic [s_line-1:0]  buffer;
    logic [31:0]        address_q;
    logic               read_q;
    logic               write_q;
    logic               resp_q;
    logic [31:0]        aligned;

    assign aligned       = {bus.address_i[31:s_offset], {s_offset{1'b0}}};
    assign bus.line_o    = buffer;
    assign bus.burst_o   = buffer[int'(count) * s_burst +: s_burst];
    assign bus.address_o = address_q;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.resp_o    = resp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            buffer    <= '0;
            address_q <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            resp_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Write wins when both requests are raised together.
                    if (bus.write_i) begin
                        buffer    <= bus.line_i;
                        address_q <= aligned;
                        count     <= '0;
                        write_q   <= 1'b1;
                        state     <= WR_BURST;
                    end else if (bus.read_i) begin
                        address_q <= aligned;
                        count     <= '0;
                        read_q    <= 1'b1;
                        state     <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (bus.resp_i) begin
                        buffer[int'(count) * s_burst +: s_burst] <= bus.burst_i;
                        if (count == last_beat) begin
                            count  <= '0;
                            read_q <= 1'b0;
                            resp_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (bus.resp_i) begin
                        if (count == last_beat) begin
                            count   <= '0;
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    resp_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
